// File: rtl/bus_capture_fifo_24bit.sv
// rtl/bus_capture_fifo_24bit.sv - bus word capture FIFO with valid/ready output and overflow flag
module bus_capture_fifo_24bit #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       bus_en_i,
    input  logic [WIDTH-1:0]           in_d,
    input  logic                       flush_i,
    output logic [WIDTH-1:0]           out_q,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       overflow_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;

    logic w_valid;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    // Handshake decode; a full FIFO still takes a word when the head leaves in the same cycle
    always_comb begin
        w_valid = (r_count != '0);
        w_full  = (r_count == DEPTH_C);
        w_pop   = w_valid & out_ready_i;
        w_push  = bus_en_i & (~w_full | w_pop);
        w_drop  = bus_en_i & ~w_push;
    end

    // Storage array; written only on an accepted push, flush discards the bus word
    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush_i && w_push) begin
            r_mem[r_wr_ptr] <= in_d;
        end
    end

    // Pointer, occupancy and sticky overflow state; reset beats flush beats push/pop
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + ONE_C;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - ONE_C;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Outputs come from registered state only, head word gated to zero when empty
    always_comb begin
        out_valid_o = w_valid;
        out_q       = w_valid ? r_mem[r_rd_ptr] : '0;
        count_o     = r_count;
        full_o      = w_full;
        overflow_o  = r_overflow;
    end

endmodule

// File: tb/tb_bus_capture_fifo_24bit.sv
// tb/tb_bus_capture_fifo_24bit.sv - directed self-checking bench for bus_capture_fifo_24bit
module tb_bus_capture_fifo_24bit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        bus_en_i;
    logic [23:0] in_d;
    logic        flush_i;
    logic [23:0] out_q;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [2:0]  count_o;
    logic        full_o;
    logic        overflow_o;

    int n_cmp = 0;
    int n_err = 0;

    bus_capture_fifo_24bit #(.WIDTH(24), .DEPTH(4)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .bus_en_i    (bus_en_i),
        .in_d        (in_d),
        .flush_i     (flush_i),
        .out_q       (out_q),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .count_o     (count_o),
        .full_o      (full_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        bus_en_i    = 1'b0;
        in_d        = 24'hzzzzzz;
        flush_i     = 1'b0;
        out_ready_i = 1'b0;
        rst_i       = 1'b0;
    endtask

    task automatic push_words(input logic [23:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            bus_en_i = 1'b1;
            in_d     = first + 24'(i);
            step();
        end
        bus_en_i = 1'b0;
        in_d     = 24'hzzzzzz;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            n_cmp++;
            if (out_valid_o !== 1'b0 || count_o !== 3'd0 || out_q !== 24'h000000 ||
                overflow_o !== 1'b0 || full_o !== 1'b0) begin
                n_err++;
                $display("FAIL reset_idle cyc=%0d: valid=%b count=%0d q=%h ovf=%b full=%b, expected 0/0/000000/0/0",
                         i, out_valid_o, count_o, out_q, overflow_o, full_o);
            end
        end
    endtask

    task automatic test_single();
        bus_en_i = 1'b1;
        in_d     = 24'hA5C3F0;
        step();
        bus_en_i = 1'b0;
        in_d     = 24'hzzzzzz;
        n_cmp++;
        if (out_valid_o !== 1'b1 || out_q !== 24'hA5C3F0 || count_o !== 3'd1) begin
            n_err++;
            $display("FAIL single_latency: valid=%b q=%h count=%0d, expected 1/a5c3f0/1", out_valid_o, out_q, count_o);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if (out_valid_o !== 1'b1 || out_q !== 24'hA5C3F0 || count_o !== 3'd1) begin
                n_err++;
                $display("FAIL single_hold cyc=%0d: valid=%b q=%h count=%0d, expected 1/a5c3f0/1", i, out_valid_o, out_q, count_o);
            end
        end
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        n_cmp++;
        if (out_valid_o !== 1'b0 || count_o !== 3'd0 || out_q !== 24'h0) begin
            n_err++;
            $display("FAIL single_pop: valid=%b count=%0d q=%h, expected 0/0/000000", out_valid_o, count_o, out_q);
        end
    endtask

    task automatic test_fill_overflow();
        push_words(24'h000001, 4);
        n_cmp++;
        if (full_o !== 1'b1 || count_o !== 3'd4 || overflow_o !== 1'b0) begin
            n_err++;
            $display("FAIL fill_full: full=%b count=%0d ovf=%b, expected 1/4/0", full_o, count_o, overflow_o);
        end
        push_words(24'h000005, 1);
        n_cmp++;
        if (overflow_o !== 1'b1 || count_o !== 3'd4 || out_q !== 24'h000001) begin
            n_err++;
            $display("FAIL fill_drop: ovf=%b count=%0d q=%h, expected 1/4/000001", overflow_o, count_o, out_q);
        end
        out_ready_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            n_cmp++;
            if (out_valid_o !== 1'b1 || out_q !== 24'(k)) begin
                n_err++;
                $display("FAIL fill_drain idx=%0d: valid=%b q=%h, expected 1/%h", k, out_valid_o, out_q, 24'(k));
            end
            step();
        end
        out_ready_i = 1'b0;
        n_cmp++;
        if (out_valid_o !== 1'b0 || count_o !== 3'd0 || overflow_o !== 1'b1) begin
            n_err++;
            $display("FAIL fill_after_drain: valid=%b count=%0d ovf=%b, expected 0/0/1", out_valid_o, count_o, overflow_o);
        end
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        n_cmp++;
        if (overflow_o !== 1'b0) begin
            n_err++;
            $display("FAIL flush_clears_ovf: ovf=%b, expected 0", overflow_o);
        end
    endtask

    task automatic test_full_push_pop();
        push_words(24'h000010, 4);
        out_ready_i = 1'b1;
        bus_en_i    = 1'b1;
        in_d        = 24'h000014;
        step();
        bus_en_i = 1'b0;
        in_d     = 24'hzzzzzz;
        n_cmp++;
        if (count_o !== 3'd4 || overflow_o !== 1'b0 || full_o !== 1'b1) begin
            n_err++;
            $display("FAIL full_pushpop: count=%0d ovf=%b full=%b, expected 4/0/1", count_o, overflow_o, full_o);
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (out_valid_o !== 1'b1 || out_q !== 24'h000011 + 24'(k)) begin
                n_err++;
                $display("FAIL full_drain idx=%0d: valid=%b q=%h, expected 1/%h", k, out_valid_o, out_q, 24'h000011 + 24'(k));
            end
            step();
        end
        out_ready_i = 1'b0;
        n_cmp++;
        if (out_valid_o !== 1'b0 || count_o !== 3'd0) begin
            n_err++;
            $display("FAIL full_empty: valid=%b count=%0d, expected 0/0", out_valid_o, count_o);
        end
    endtask

    task automatic test_streaming();
        out_ready_i = 1'b1;
        bus_en_i    = 1'b1;
        in_d        = 24'h100000;
        step();
        for (int i = 1; i < 20; i++) begin
            n_cmp++;
            if (out_valid_o !== 1'b1 || out_q !== 24'h100000 + 24'(i - 1) || count_o !== 3'd1) begin
                n_err++;
                $display("FAIL stream idx=%0d: valid=%b q=%h count=%0d, expected 1/%h/1",
                         i - 1, out_valid_o, out_q, count_o, 24'h100000 + 24'(i - 1));
            end
            in_d = 24'h100000 + 24'(i);
            step();
        end
        bus_en_i = 1'b0;
        in_d     = 24'hzzzzzz;
        n_cmp++;
        if (out_valid_o !== 1'b1 || out_q !== 24'h100013 || count_o !== 3'd1) begin
            n_err++;
            $display("FAIL stream_last: valid=%b q=%h count=%0d, expected 1/100013/1", out_valid_o, out_q, count_o);
        end
        step();
        out_ready_i = 1'b0;
        n_cmp++;
        if (out_valid_o !== 1'b0 || count_o !== 3'd0) begin
            n_err++;
            $display("FAIL stream_empty: valid=%b count=%0d, expected 0/0", out_valid_o, count_o);
        end
    endtask

    // use_reset selects rst_i instead of flush_i as the clearing input
    task automatic test_clear_mid(input bit use_reset);
        push_words(24'h000021, 5);
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        n_cmp++;
        if (count_o !== 3'd3 || overflow_o !== 1'b1 || out_q !== 24'h000022) begin
            n_err++;
            $display("FAIL clear_setup rst=%0d: count=%0d ovf=%b q=%h, expected 3/1/000022", use_reset, count_o, overflow_o, out_q);
        end
        if (use_reset) rst_i = 1'b1;
        else           flush_i = 1'b1;
        bus_en_i = 1'b1;
        in_d     = 24'hFFFFFF;
        step();
        idle_inputs();
        n_cmp++;
        if (count_o !== 3'd0 || out_valid_o !== 1'b0 || overflow_o !== 1'b0 || out_q !== 24'h0) begin
            n_err++;
            $display("FAIL clear rst=%0d: count=%0d valid=%b ovf=%b q=%h, expected 0/0/0/000000",
                     use_reset, count_o, out_valid_o, overflow_o, out_q);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (out_valid_o !== 1'b0 || out_q === 24'hFFFFFF) begin
                n_err++;
                $display("FAIL clear_no_ghost rst=%0d cyc=%0d: valid=%b q=%h, expected 0/000000", use_reset, i, out_valid_o, out_q);
            end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_fill_overflow();
        test_full_push_pop();
        test_streaming();
        test_clear_mid(1'b0);
        test_clear_mid(1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bus_capture_fifo_24bit.md
Name: bus_capture_fifo_24bit

Overview:
- Receiving end of the shared 24-bit tri-state word bus. Bus drivers put a word on the bus and assert their enable; this block samples the bus while that enable is high.
- Samples each driven word into a small synchronous FIFO and presents the words in order on a valid/ready interface to the consumer (instruction register / prefetch logic).
- Decouples the bus-side drive cycle from consumer stalls. Reports fill level, full status and lost words.

Parameters:
- WIDTH, 24, word width in bits. Must match the bus driver width.
- DEPTH, 4, FIFO entries. Must be a power of two, ≥2.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- bus_en_i  input  1  bus driver enable; high means in_d carries a valid word this cycle.
- in_d  input  WIDTH  shared bus data; sampled only when bus_en_i=1.
- flush_i  input  1  synchronous clear of all FIFO contents and the overflow flag.
- out_q  output  WIDTH  head-of-FIFO word.
- out_valid_o  output  1  out_q holds a valid word.
- out_ready_i  input  1  consumer accepts out_q this cycle.
- count_o  output  $clog2(DEPTH+1)  number of stored words, 0..DEPTH.
- full_o  output  1  count_o==DEPTH.
- overflow_o  output  1  sticky: a bus word was dropped.

Behaviour:
- Reset (rst_i=1 at clock edge):
  - read pointer, write pointer and count_o go to 0.
  - out_valid_o=0, full_o=0, overflow_o=0, out_q=0.
  - Reset overrides every other input. Reset mid-stream discards all stored words.
- Definitions:
  - pop = out_valid_o & out_ready_i.
  - push_req = bus_en_i.
  - push = push_req & (!full_o | pop). A write into a full FIFO is accepted in the same cycle as a pop.
- Push: in_d is written at wr_ptr; wr_ptr increments modulo DEPTH (natural wrap, no skipped entries).
- Pop: rd_ptr increments modulo DEPTH.
- Count update: count_o += push - pop. Push and pop together leave the count unchanged.
- Dropped word: push_req & !push sets overflow_o=1. The word is lost and the FIFO contents are unchanged. overflow_o stays set until flush_i or rst_i.
- Flush: flush_i=1 clears pointers, count_o and overflow_o.
  - Flush has priority over a same-cycle push and pop. The bus word in that cycle is discarded, and overflow_o is not set for it.
  - The consumer may see out_valid_o=1 in the flush cycle. That word is not considered delivered.
- Outputs:
  - out_valid_o = (count_o != 0).
  - out_q = mem[rd_ptr] when out_valid_o=1, otherwise 0.
  - Outputs are derived from registered state only; there is no combinational path from in_d or bus_en_i to any output.
- Latency:
  - A word sampled at edge N into an empty FIFO appears on out_q with out_valid_o=1 after edge N (one cycle).
  - There is no bypass.
- Throughput: one push and one pop per cycle, sustained at any fill level.
- Ordering: strict FIFO order. No word is ever duplicated.
- Hold: when out_valid_o=1 and out_ready_i=0, out_q and out_valid_o hold stable.
- Undriven bus: in_d is ignored whenever bus_en_i=0, so a floating bus never enters the FIFO.
- Invariant: full_o=1 implies out_valid_o=1.

Test Plan:
- Reset/idle: assert rst_i 2 cycles, then bus_en_i=0 for 10 cycles → out_valid_o=0, count_o=0, out_q=24'h000000, overflow_o=0.
- Single word latency: in_d=24'hA5C3F0, bus_en_i=1 at edge N, out_ready_i=0 → after edge N: out_valid_o=1, out_q=24'hA5C3F0, count_o=1. With out_ready_i=1 at edge N+3 → after edge N+3: out_valid_o=0, count_o=0.
- Fill and overflow: push 24'h000001..24'h000005 on consecutive cycles with out_ready_i=0 → full_o=1 and count_o=4 after the 4th push; 5th word dropped, overflow_o=1. Drain → outputs 1,2,3,4 in order; overflow_o still 1.
- Full with simultaneous push/pop: FIFO full holding 10,11,12,13; push 24'h000014 with out_ready_i=1 → count_o stays 4, overflow_o=0. Drain order is 11,12,13,14.
- Wrap-around streaming: out_ready_i=1, push 24'h100000+i for i=0..19 back-to-back → out_q matches each word one cycle later, count_o ≤1 throughout, no gaps, pointers wrap 5 times.
- Flush and reset mid-stream:
  - 3 words stored, overflow_o=1, then flush_i=1 together with bus_en_i=1, in_d=24'hFFFFFF → next cycle count_o=0, out_valid_o=0, overflow_o=0; 24'hFFFFFF never appears on out_q.
  - Repeat the same setup with rst_i instead of flush_i → same result.
